lifo_stack_param: RTL and testbench

LIFO_STACK_PARAM -- requirements
Module: lifo_stack_param

---
 rtl/lifo_stack_param.sv | 114 +++++++++++
 tb/tb_lifo_stack_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_param.sv
// Purpose : parameterised LIFO stack with a registered pop port, a combinational
//           top-of-stack peek, occupancy flags and sticky overflow/underflow flags.
// Latency : a pop (or push+pop) shows on dataout with dout_valid one clock after
//           the accepting edge; top/count/flags follow the registered state with
//           no added delay.
// Backpressure : none. A push to a full stack is dropped and sets overflow. A pop
//           from an empty stack is ignored and sets underflow. A push+pop pair is
//           always accepted.
// Ports   : clock, reset (sync, active-high)
//           wn/rn = push/pop requests, datain = push data, err_clr = clear sticky errors
//           dataout/dout_valid = popped word and its one-cycle strobe
//           top = peek of the top entry (0 when empty), count = stored entries
//           full/empty/almost_full = occupancy decodes, overflow/underflow = sticky errors
module lifo_stack_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wn,
  input  logic                         rn,
  input  logic                         err_clr,
  input  logic [WIDTH-1:0]             datain,
  output logic [WIDTH-1:0]             dataout,
  output logic                         dout_valid,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  // A threshold above DEPTH can never be reached; keep it from truncating into a small value.
  localparam bit            AF_NEVER = (AF_LEVEL > DEPTH);
  localparam logic [CW-1:0] AF_C     = AF_NEVER ? DEPTH_C : CW'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] cnt_m1;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic          push_only;
  logic          pop_only;
  logic          both;
  logic          push_ok;
  logic          pop_ok;

  assign push_only = wn & ~rn;
  assign pop_only  = rn & ~wn;
  assign both      = wn & rn;

  assign push_ok = push_only & ~full;
  assign pop_ok  = pop_only & ~empty;

  // cnt_m1 wraps when empty, but top_idx is only used behind an !empty qualifier.
  assign cnt_m1  = count - CW'(1);
  assign top_idx = cnt_m1[IW-1:0];
  assign wr_idx  = count[IW-1:0];

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almost_full = !AF_NEVER && (count >= AF_C);

  // Gating on empty hides stale (or never-reset) memory contents.
  assign top = empty ? '0 : mem[top_idx];

  // Storage carries no reset; only entries below count are ever visible.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push_ok) begin
        mem[wr_idx] <= datain;
      end else if (both && !empty) begin
        mem[top_idx] <= datain;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      dataout    <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      // Push+pop leaves count alone, so it can neither overflow nor underflow.
      if (push_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok) begin
        count <= cnt_m1;
      end

      dout_valid <= pop_ok | both;

      // Push+pop on an empty stack passes datain straight through.
      if (both) begin
        dataout <= empty ? datain : mem[top_idx];
      end else if (pop_ok) begin
        dataout <= mem[top_idx];
      end

      // A new error event wins over a simultaneous clear.
      overflow  <= (push_only & full)  | (overflow  & ~err_clr);
      underflow <= (pop_only  & empty) | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_lifo_stack_param.sv
// Bench for lifo_stack_param (WIDTH=8, DEPTH=4, AF_LEVEL=3): directed vectors with
// literal expectations, plus a queue-based stack model compared every negedge.
module tb_lifo_stack_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;

  logic             clock;
  logic             reset;
  logic             wn;
  logic             rn;
  logic             err_clr;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             dout_valid;
  logic [WIDTH-1:0] top;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_errors = 0;

  lifo_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clock       (clock),
    .reset       (reset),
    .wn          (wn),
    .rn          (rn),
    .err_clr     (err_clr),
    .datain      (datain),
    .dataout     (dataout),
    .dout_valid  (dout_valid),
    .top         (top),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model: a plain queue used as a stack ----------------
  int stk[$];
  int m_dout  = 0;
  bit m_dv    = 0;
  bit m_ovf   = 0;
  bit m_udf   = 0;
  bit m_known = 0;

  always @(posedge clock) begin
    if (reset) begin
      stk.delete();
      m_dout  = 0;
      m_dv    = 0;
      m_ovf   = 0;
      m_udf   = 0;
      m_known = 1;
    end else begin
      bit new_ovf;
      bit new_udf;
      new_ovf = 0;
      new_udf = 0;
      m_dv    = 0;
      if (wn && rn) begin
        if (stk.size() == 0) begin
          m_dout = int'(datain);
        end else begin
          m_dout = stk[$];
          stk[$] = int'(datain);
        end
        m_dv = 1;
      end else if (wn) begin
        if (stk.size() == DEPTH) new_ovf = 1;
        else stk.push_back(int'(datain));
      end else if (rn) begin
        if (stk.size() == 0) new_udf = 1;
        else begin
          m_dout = stk.pop_back();
          m_dv   = 1;
        end
      end
      m_ovf = new_ovf | (m_ovf & !err_clr);
      m_udf = new_udf | (m_udf & !err_clr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_known) begin
      int sz;
      sz = stk.size();
      chk("m_count",  int'(count),       sz);
      chk("m_empty",  int'(empty),       int'(sz == 0));
      chk("m_full",   int'(full),        int'(sz == DEPTH));
      chk("m_afull",  int'(almost_full), int'(sz >= AFL));
      chk("m_top",    int'(top),         (sz == 0) ? 0 : stk[$]);
      chk("m_dout",   int'(dataout),     m_dout);
      chk("m_dvalid", int'(dout_valid),  int'(m_dv));
      chk("m_ovf",    int'(overflow),    int'(m_ovf));
      chk("m_udf",    int'(underflow),   int'(m_udf));
    end
  end

  // One clock of stimulus; returns just after the edge so outputs show its effect.
  task automatic tick(input logic w, input logic r, input logic c, input logic [WIDTH-1:0] d);
    @(negedge clock);
    wn      = w;
    rn      = r;
    err_clr = c;
    datain  = d;
    @(posedge clock);
    #1;
    wn      = 1'b0;
    rn      = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    wn    = 1'b1;   // must be ignored while reset is high
    datain = 8'hEE;
    @(posedge clock);
    #1;
    reset = 1'b0;
    wn    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; wn = 1'b0; rn = 1'b0; err_clr = 1'b0; datain = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    chk("rst_dv",    int'(dout_valid), 0);
    chk("rst_top",   int'(top),   0);

    // LIFO order
    tick(1, 0, 0, 100);
    tick(1, 0, 0, 150);
    tick(1, 0, 0, 200);
    chk("p3_top", int'(top), 200);
    tick(0, 1, 0, 0);
    chk("pop1_dout", int'(dataout), 200);
    chk("pop1_dv",   int'(dout_valid), 1);
    tick(0, 1, 0, 0);
    chk("pop2_dout", int'(dataout), 150);
    chk("pop2_dv",   int'(dout_valid), 1);
    tick(0, 1, 0, 0);
    chk("pop3_dout", int'(dataout), 100);
    chk("pop3_dv",   int'(dout_valid), 1);
    chk("pop3_empty", int'(empty), 1);
    chk("pop3_count", int'(count), 0);
    tick(0, 0, 0, 0);
    chk("idle_dv",   int'(dout_valid), 0);
    chk("idle_dout", int'(dataout), 100);

    // Fill, overflow, clear
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 2);
    chk("af_c2", int'(almost_full), 0);
    tick(1, 0, 0, 3);
    chk("af_c3", int'(almost_full), 1);
    chk("full_c3", int'(full), 0);
    tick(1, 0, 0, 4);
    tick(1, 0, 0, 5);
    chk("ovf_full",  int'(full), 1);
    chk("ovf_af",    int'(almost_full), 1);
    chk("ovf_count", int'(count), 4);
    chk("ovf_flag",  int'(overflow), 1);
    chk("ovf_top",   int'(top), 4);
    tick(0, 0, 1, 0);
    chk("ovf_clr", int'(overflow), 0);

    // Replace-top while full: accepted, no overflow
    tick(1, 1, 0, 9);
    chk("rep_full_dout", int'(dataout), 4);
    chk("rep_full_top",  int'(top), 9);
    chk("rep_full_cnt",  int'(count), 4);
    chk("rep_full_ovf",  int'(overflow), 0);

    // Clear coinciding with a new overflow: flag stays set
    tick(1, 0, 1, 6);
    chk("ovf_clr_race", int'(overflow), 1);
    tick(0, 0, 1, 0);
    chk("ovf_clr2", int'(overflow), 0);

    tick(0, 1, 0, 0);
    chk("drain1", int'(dataout), 9);
    tick(0, 1, 0, 0);
    chk("drain2", int'(dataout), 3);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("drain4", int'(dataout), 1);

    // Underflow on empty pop
    tick(0, 1, 0, 0);
    chk("udf_flag", int'(underflow), 1);
    chk("udf_dv",   int'(dout_valid), 0);
    chk("udf_dout", int'(dataout), 1);
    chk("udf_cnt",  int'(count), 0);
    tick(0, 0, 1, 0);
    chk("udf_clr", int'(underflow), 0);

    // Replace-top with entries
    tick(1, 0, 0, 10);
    tick(1, 0, 0, 20);
    tick(1, 1, 0, 30);
    chk("rep_dout",  int'(dataout), 20);
    chk("rep_top",   int'(top), 30);
    chk("rep_count", int'(count), 2);
    chk("rep_dv",    int'(dout_valid), 1);
    tick(0, 1, 0, 0);
    chk("rep_pop1", int'(dataout), 30);
    tick(0, 1, 0, 0);
    chk("rep_pop2", int'(dataout), 10);

    // Pass-through on empty
    tick(1, 1, 0, 77);
    chk("pt_dout",  int'(dataout), 77);
    chk("pt_count", int'(count), 0);
    chk("pt_udf",   int'(underflow), 0);
    chk("pt_dv",    int'(dout_valid), 1);

    // Mid-operation reset
    tick(1, 0, 0, 5);
    tick(1, 0, 0, 6);
    tick(1, 0, 0, 7);
    do_reset();
    chk("mrst_count", int'(count), 0);
    chk("mrst_empty", int'(empty), 1);
    chk("mrst_top",   int'(top), 0);
    chk("mrst_dout",  int'(dataout), 0);
    tick(1, 0, 0, 9);
    chk("mrst_push_cnt", int'(count), 1);
    chk("mrst_push_top", int'(top), 9);
    tick(0, 1, 0, 0);
    chk("mrst_pop_dout",  int'(dataout), 9);
    chk("mrst_pop_empty", int'(empty), 1);

    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
